cntr8_sched: RTL and testbench
==============================

# cntr8_sched

Two-requester scheduler for the 8-bit up/down counter (cntr8).
- Arbitrates round-robin between two requesters.
- Drives the counter's `load`, `inc` and `d_in` inputs to run one command at a time: load a value, count up N, count down N, or hold N cycles.
- Parks the counter when no command is running by reloading the counter's own output, so the count never drifts.
- Sits between the requesting logic and the counter instance, in the same clock domain.

## Interface
Parameters:
- DATA_W, 8, width of counter value and of the command argument

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  synchronous active-low reset
- req0, req1  in  1  request from requester 0/1; held high until its done pulse
- op0, op1  in  2  command: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD; stable while req high
- arg0, arg1  in  DATA_W  LOAD value or step/cycle count N; stable while req high
- cnt_val  in  DATA_W  current counter output (cntr8 d_out)
- gnt0, gnt1  out  1  requester 0/1 owns the counter; high for the whole EXEC phase
- done0, done1  out  1  one-cycle pulse when that requester's command finishes
- busy  out  1  high in EXEC and DONE
- load  out  1  to counter; 1 = load d_in this edge
- inc  out  1  to counter; with load=0: 1 = increment, 0 = decrement
- d_in  out  DATA_W  to counter load data

## Operation
- State register: IDLE, EXEC, DONE. Internal registers:
  - owner (1 bit)
  - op_q (2 bits)
  - arg_q (DATA_W)
  - remaining step count rem (DATA_W)
  - round-robin pointer rr (1 bit; 0 = requester 0 has priority)
- IDLE:
  - Outputs: load=1, d_in=cnt_val, inc=0 (hold).
  - If req0 or req1 is high, select the owner:
    - only one requester is high: that requester;
    - both are high: requester rr.
  - Capture the owner's op/arg into op_q/arg_q. Set rem=arg.
  - Go to EXEC. Otherwise stay in IDLE.
- EXEC, gnt[owner]=1:
  - LOAD: load=1, d_in=arg_q for exactly 1 cycle, then go to DONE.
  - UP: load=0, inc=1 for each cycle while rem≠0; decrement rem each cycle. When rem reaches 0, go to DONE.
  - DOWN: same as UP with inc=0.
  - HOLD: load=1, d_in=cnt_val for rem cycles.
  - UP, DOWN or HOLD with N=0: EXEC lasts exactly 1 cycle with hold outputs (load=1, d_in=cnt_val), then DONE. No counter step is taken.
- DONE:
  - Outputs: done[owner]=1 for one cycle, gnt=00, hold outputs.
  - Set rr = ~owner.
  - Go to IDLE.
- Counter arithmetic wraps modulo 2^DATA_W; no saturation is applied. Example: UP 3 from 8'hFE yields 8'h01.
- Dropping req during EXEC has no effect: the command completes and done still pulses. Changing op/arg during EXEC is ignored because the values were captured.
- A requester that raises req again right after its done pulse goes through normal arbitration. The other requester wins if it is also requesting.
- The two gnt lines are never high together, and the two done lines are never high together.

## Timing
- Reset (reset_n=0 at an edge):
  - Next cycle: state=IDLE, rr=0, gnt=00, done=00, busy=0, load=1, inc=0, d_in=cnt_val.
  - Reset during EXEC aborts the command without a done pulse.
  - reset_n overrides every other input.
- req seen high in IDLE at edge t → EXEC starts at cycle t+1; gnt high from t+1.
- Command of N steps (N≥1): EXEC spans cycles t+1 … t+N; DONE at t+N+1; IDLE at t+N+2.
- LOAD, and commands with N=0: EXEC is 1 cycle; DONE at t+2.
- Counter values:
  - cnt_val shows the final result by the first DONE cycle.
  - A LOAD value is visible at t+2.
- Back-to-back service: a requester's minimum turnaround is 3 cycles (IDLE, EXEC, DONE) per command.
- Outputs are combinational from registered state only; there is no input-to-output combinational path except d_in=cnt_val while holding.

## Test plan
- Reset, then req0 with LOAD 8'h5A → gnt0 at cycle 1, done0 at cycle 2, cnt_val=8'h5A from cycle 2 and stable thereafter.
- cnt=8'h10; req1 UP 4 → inc=1/load=0 for 4 cycles, cnt_val=8'h14 at done1. Then req1 DOWN 5 → cnt_val=8'h0F.
- Wrap: LOAD 8'hFE then UP 3 → 8'h01. LOAD 8'h01 then DOWN 2 → 8'hFF.
- req0 and req1 both high with continuous commands UP 1 → grants alternate 0,1,0,1 starting with 0 after reset. Gnt lines are never simultaneous.
- UP 0 and HOLD 3 → no count change. Durations: UP 0 has EXEC of 1 cycle; HOLD 3 has EXEC of 3 cycles. Each gives one done pulse.
- reset_n low mid-way through UP 10 → next cycle IDLE, gnt=00, no done pulse, rr=0. The counter value equals the value after the steps taken before the abort.

Source files
------------

// File: rtl/cntr8_sched.sv
// Round-robin two-requester scheduler driving an 8-bit up/down counter.
// One command (LOAD / UP N / DOWN N / HOLD N) runs at a time; otherwise the counter is parked.
module cntr8_sched #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [DATA_W-1:0] arg0,
    input  logic [DATA_W-1:0] arg1,
    input  logic [DATA_W-1:0] cnt_val,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              busy,
    output logic              load,
    output logic              inc,
    output logic [DATA_W-1:0] d_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [DATA_W-1:0] REM_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] REM_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_s;
    logic              owner_r;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] arg_r;
    logic [DATA_W-1:0] rem_r;
    logic              rr_r;

    logic              pick_s;
    logic [1:0]        sel_op_s;
    logic [DATA_W-1:0] sel_arg_s;

    // Arbitration: a lone requester wins outright; on contention the rr pointer decides.
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = rr_r;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        if (pick_s) begin
            sel_op_s  = op1;
            sel_arg_s = arg1;
        end else begin
            sel_op_s  = op0;
            sel_arg_s = arg0;
        end
    end

    // Next-state and counter-control decode; the default outputs park the counter on its own value.
    always_comb begin
        state_s = state_r;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        busy    = 1'b0;
        load    = 1'b1;
        inc     = 1'b0;
        d_in    = cnt_val;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                busy = 1'b1;
                gnt0 = ~owner_r;
                gnt1 = owner_r;
                if (op_r == OP_LOAD) begin
                    d_in    = arg_r;
                    state_s = DONE;
                end else if (rem_r == REM_ZERO) begin
                    state_s = DONE;
                end else begin
                    if (op_r == OP_HOLD) begin
                        load = 1'b1;
                    end else begin
                        load = 1'b0;
                        inc  = (op_r == OP_UP);
                    end
                    if (rem_r == REM_ONE) begin
                        state_s = DONE;
                    end else begin
                        state_s = EXEC;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done0   = ~owner_r;
                done1   = owner_r;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, captured command and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            op_r    <= 2'b00;
            arg_r   <= REM_ZERO;
            rem_r   <= REM_ZERO;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_r <= pick_s;
                        op_r    <= sel_op_s;
                        arg_r   <= sel_arg_s;
                        rem_r   <= sel_arg_s;
                    end
                end
                EXEC: begin
                    if (rem_r != REM_ZERO) begin
                        rem_r <= rem_r - REM_ONE;
                    end
                end
                DONE: begin
                    rr_r <= ~owner_r;
                end
                default: begin
                    rr_r <= rr_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cntr8_sched.sv
// Self-checking bench for cntr8_sched with a behavioural cntr8 model closing the loop.
module tb_cntr8_sched;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [7:0] arg0 = 8'h00, arg1 = 8'h00;
    logic [7:0] cnt_val = 8'h00;
    logic       gnt0, gnt1, done0, done1, busy, load, inc;
    logic [7:0] d_in;

    int checks = 0;
    int errors = 0;
    logic       mon_en = 1'b0;
    logic [7:0] model_cnt = 8'h00;

    typedef struct {
        logic       who;
        logic [7:0] cnt;
        int         len;
        int         steps;
    } exp_t;
    exp_t sb[$];

    cntr8_sched #(.DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .arg0(arg0), .arg1(arg1), .cnt_val(cnt_val),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .load(load), .inc(inc), .d_in(d_in)
    );

    always #5 clk = ~clk;

    // cntr8 behaviour: load wins, otherwise count up or down
    always @(posedge clk) begin
        if (load) cnt_val <= d_in;
        else if (inc) cnt_val <= cnt_val + 8'd1;
        else cnt_val <= cnt_val - 8'd1;
    end

    // Per-cycle invariants
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((gnt0 & gnt1) !== 1'b0) begin
                errors++;
                $display("FAIL gnt_exclusive gnt0=%b gnt1=%b required not both", gnt0, gnt1);
            end
            checks++;
            if ((done0 & done1) !== 1'b0) begin
                errors++;
                $display("FAIL done_exclusive done0=%b done1=%b required not both", done0, done1);
            end
            checks++;
            if (busy !== (gnt0 | gnt1 | done0 | done1)) begin
                errors++;
                $display("FAIL busy_phase busy=%b required %b", busy, gnt0 | gnt1 | done0 | done1);
            end
        end
    end

    task automatic set_req(input logic who, input logic v, input logic [1:0] op, input logic [7:0] arg);
        if (who) begin
            req1 = v; op1 = op; arg1 = arg;
        end else begin
            req0 = v; op0 = op; arg0 = arg;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_cmd(input logic who, input logic [1:0] op, input logic [7:0] arg);
        exp_t e;
        int cyc = 0, len = 0, steps = 0, dir_bad = 0, first_gnt = 0, done_cyc = 0;
        logic got = 1'b0;
        e.who   = who;
        e.len   = (op == OP_LOAD || arg == 8'd0) ? 1 : int'(arg);
        e.steps = (op == OP_UP || op == OP_DOWN) ? int'(arg) : 0;
        case (op)
            OP_LOAD: model_cnt = arg;
            OP_UP:   model_cnt = model_cnt + arg;
            OP_DOWN: model_cnt = model_cnt - arg;
            default: model_cnt = model_cnt;
        endcase
        e.cnt = model_cnt;
        sb.push_back(e);
        @(negedge clk);
        set_req(who, 1'b1, op, arg);
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if ((who ? gnt1 : gnt0) === 1'b1) begin
                len++;
                if (first_gnt == 0) first_gnt = cyc;
                if (load === 1'b0) begin
                    steps++;
                    if (inc !== (op == OP_UP)) dir_bad++;
                end
            end
            if ((who ? done1 : done0) === 1'b1) begin
                got = 1'b1;
                done_cyc = cyc;
                set_req(who, 1'b0, op, arg);
            end
        end
        set_req(who, 1'b0, op, arg);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd_done_timeout who=%0d op=%0d got no done within %0d cycles", who, op, cyc);
        end
        checks++;
        if (cnt_val !== e.cnt) begin
            errors++;
            $display("FAIL cmd_count op=%0d arg=%0d cnt_val=%h required %h", op, arg, cnt_val, e.cnt);
        end
        checks++;
        if (len !== e.len) begin
            errors++;
            $display("FAIL cmd_exec_len op=%0d arg=%0d got %0d required %0d", op, arg, len, e.len);
        end
        checks++;
        if (steps !== e.steps || dir_bad !== 0) begin
            errors++;
            $display("FAIL cmd_steps op=%0d steps=%0d bad_dir=%0d required %0d/0", op, steps, dir_bad, e.steps);
        end
        checks++;
        if (first_gnt !== 1 || done_cyc !== e.len + 1) begin
            errors++;
            $display("FAIL cmd_timing gnt at %0d done at %0d required 1 and %0d", first_gnt, done_cyc, e.len + 1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, done0, done1, busy, load, inc} !== 7'b0000010 || d_in !== cnt_val) begin
            errors++;
            $display("FAIL reset_outputs g/d/busy/load/inc=%b d_in=%h required 0000010 d_in=%h",
                     {gnt0, gnt1, done0, done1, busy, load, inc}, d_in, cnt_val);
        end
        reset_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_load();
        run_cmd(1'b0, OP_LOAD, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cnt_val !== 8'h5A) begin
                errors++;
                $display("FAIL load_stable cycle %0d cnt_val=%h required 5a", i, cnt_val);
            end
        end
    endtask

    task automatic test_up_down();
        run_cmd(1'b1, OP_LOAD, 8'h10);
        run_cmd(1'b1, OP_UP, 8'd4);
        checks++;
        if (cnt_val !== 8'h14) begin
            errors++;
            $display("FAIL up4 cnt_val=%h required 14", cnt_val);
        end
        run_cmd(1'b1, OP_DOWN, 8'd5);
        checks++;
        if (cnt_val !== 8'h0F) begin
            errors++;
            $display("FAIL down5 cnt_val=%h required 0f", cnt_val);
        end
    endtask

    task automatic test_wrap();
        run_cmd(1'b0, OP_LOAD, 8'hFE);
        run_cmd(1'b0, OP_UP, 8'd3);
        checks++;
        if (cnt_val !== 8'h01) begin
            errors++;
            $display("FAIL wrap_up cnt_val=%h required 01", cnt_val);
        end
        run_cmd(1'b1, OP_LOAD, 8'h01);
        run_cmd(1'b1, OP_DOWN, 8'd2);
        checks++;
        if (cnt_val !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_down cnt_val=%h required ff", cnt_val);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int n = 0, cyc = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            model_cnt = model_cnt + 8'd1;
            e.who = i[0];
            e.cnt = model_cnt;
            e.len = 1;
            e.steps = 1;
            sb.push_back(e);
        end
        set_req(1'b0, 1'b1, OP_UP, 8'd1);
        set_req(1'b1, 1'b1, OP_UP, 8'd1);
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                e = sb.pop_front();
                n++;
                checks++;
                if (done1 !== e.who || cnt_val !== e.cnt) begin
                    errors++;
                    $display("FAIL rr_order grant %0d owner=%0d cnt=%h required owner=%0d cnt=%h",
                             n, done1, cnt_val, e.who, e.cnt);
                end
                if (n == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_timeout saw %0d done pulses required 4", n);
            sb.delete();
        end
    endtask

    task automatic test_zero_hold();
        run_cmd(1'b0, OP_LOAD, 8'h77);
        run_cmd(1'b0, OP_UP, 8'd0);
        run_cmd(1'b1, OP_HOLD, 8'd3);
        checks++;
        if (cnt_val !== 8'h77) begin
            errors++;
            $display("FAIL zero_hold cnt_val=%h required 77", cnt_val);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0, cyc = 0;
        run_cmd(1'b0, OP_LOAD, 8'h20);
        @(negedge clk);
        set_req(1'b1, 1'b1, OP_UP, 8'd10);
        repeat (4) @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_gnt gnt1=%b required 1", gnt1);
        end
        reset_n = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, done0, done1, busy, load, inc} !== 7'b0000010 || cnt_val !== 8'h24) begin
            errors++;
            $display("FAIL abort_state g/d/busy/load/inc=%b cnt=%h required 0000010 cnt=24",
                     {gnt0, gnt1, done0, done1, busy, load, inc}, cnt_val);
        end
        reset_n = 1'b1;
        model_cnt = 8'h24;
        repeat (5) begin
            @(negedge clk);
            if (done0 === 1'b1 || done1 === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done saw %0d done pulses required 0", dones);
        end
        set_req(1'b0, 1'b1, OP_LOAD, 8'h33);
        set_req(1'b1, 1'b1, OP_LOAD, 8'h44);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_rr gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        while (req0 || req1) begin
            if (done0 === 1'b1) req0 = 1'b0;
            if (done1 === 1'b1) req1 = 1'b0;
            if (cyc > 40) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        model_cnt = 8'h44;
        checks++;
        if (cnt_val !== 8'h44 || cyc > 40) begin
            errors++;
            $display("FAIL abort_followup cnt_val=%h cycles=%0d required 44 within 40", cnt_val, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up_down();
        test_wrap();
        test_round_robin();
        test_zero_hold();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
